spi_sckgen: RTL and testbench

- Next-generation SPI serial-clock engine: programmable divider, SPI mode (CPOL/CPHA), per-transfer bit count, and chip-select lead/trail/inter-transfer gap timing.
- Emits the serial clock, one-cycle edge strobes, and mode-resolved sample/shift strobes for the shift register.
- Sits between the SPI register file (config, start) and the shift/chip-select datapath.

---
 rtl/spi_sckgen_pkg.sv | 17 +
 rtl/spi_sckgen_if.sv | 40 ++++
 rtl/spi_sckgen_div.sv | 36 +++
 rtl/spi_sckgen.sv | 194 +++++++++++++++++++
 tb/tb_spi_sckgen.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_sckgen_pkg.sv
// Shared definitions for the SPI serial-clock engine: FSM state encoding and
// default field widths used by the interface, the top and the bench.
package spi_define;

  localparam int DIV_WIDTH_DEF = 8;
  localparam int LEN_WIDTH_DEF = 5;
  localparam int DLY_WIDTH_DEF = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    XFER  = 3'd2,
    TRAIL = 3'd3,
    GAP   = 3'd4
  } state_e;

endpackage

// File: rtl/spi_sckgen_if.sv
// Control/config/status bundle between the SPI register file (master side)
// and the serial-clock engine (slave side).
interface spi_sckgen_if import spi_define::*; #(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF,
  parameter int LEN_WIDTH = LEN_WIDTH_DEF,
  parameter int DLY_WIDTH = DLY_WIDTH_DEF
) ();

  logic                 en_i;
  logic                 start_i;
  logic                 ready_o;
  logic                 cpol_i;
  logic                 cpha_i;
  logic [DIV_WIDTH-1:0] clk_div_i;
  logic [LEN_WIDTH-1:0] len_i;
  logic [DLY_WIDTH-1:0] lead_i;
  logic [DLY_WIDTH-1:0] trail_i;
  logic [DLY_WIDTH-1:0] gap_i;
  logic                 sck_o;
  logic                 pos_edge_o;
  logic                 neg_edge_o;
  logic                 sample_o;
  logic                 shift_o;
  logic                 cs_active_o;
  logic                 busy_o;
  logic                 done_o;

  modport master (
    output en_i, start_i, cpol_i, cpha_i, clk_div_i, len_i, lead_i, trail_i, gap_i,
    input  ready_o, sck_o, pos_edge_o, neg_edge_o, sample_o, shift_o,
           cs_active_o, busy_o, done_o
  );

  modport slave (
    input  en_i, start_i, cpol_i, cpha_i, clk_div_i, len_i, lead_i, trail_i, gap_i,
    output ready_o, sck_o, pos_edge_o, neg_edge_o, sample_o, shift_o,
           cs_active_o, busy_o, done_o
  );

endinterface

// File: rtl/spi_sckgen_div.sv
// Loadable down-counter with a zero flag; shared by the SCK half-period timer
// and the lead/trail/gap delay timer.
module spi_sckgen_div #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Load has priority; decrement saturates at zero so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/spi_sckgen.sv
// SPI serial-clock engine: CS lead/trail/gap sequencing, divided SCK with
// CPOL/CPHA handling, and registered edge/sample/shift/done strobes.
module spi_sckgen import spi_define::*; #(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF,
  parameter int LEN_WIDTH = LEN_WIDTH_DEF,
  parameter int DLY_WIDTH = DLY_WIDTH_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  spi_sckgen_if.slave  bus
);

  state_e state_q, state_d;

  logic                 cpol_q, cpol_d;
  logic                 cpha_q, cpha_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [DLY_WIDTH-1:0] trail_q, trail_d;
  logic [DLY_WIDTH-1:0] gap_q, gap_d;
  logic [LEN_WIDTH:0]   edge_cnt_q, edge_cnt_d;
  logic                 xfer_end_q, xfer_end_d;

  logic sck_q, sck_d;
  logic pos_q, pos_d;
  logic neg_q, neg_d;
  logic sample_q, sample_d;
  logic shift_q, shift_d;
  logic cs_q, cs_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic ready_q, ready_d;

  logic                 accept;
  logic                 fire;
  logic                 final_edge;
  logic                 leading;
  logic                 half_zero, half_load, half_dec;
  logic                 dly_zero, dly_load, dly_dec;
  logic [DLY_WIDTH-1:0] dly_val;

  assign accept     = (state_q == IDLE) && bus.en_i && bus.start_i && ready_q;
  assign fire       = (state_q == XFER) && bus.en_i && half_zero && !xfer_end_q;
  assign final_edge = (edge_cnt_q == {len_q, 1'b1});
  assign leading    = ~edge_cnt_q[0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Dropping en_i returns to IDLE from anywhere without a done pulse.
  always_comb begin
    state_d = state_q;
    if (!bus.en_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (accept)     state_d = LEAD;
        LEAD:    if (dly_zero)   state_d = XFER;
        XFER:    if (xfer_end_q) state_d = TRAIL;
        TRAIL:   if (dly_zero)   state_d = GAP;
        GAP:     if (dly_zero)   state_d = IDLE;
        default:                 state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    sck_d    = sck_q;
    pos_d    = 1'b0;
    neg_d    = 1'b0;
    sample_d = 1'b0;
    shift_d  = 1'b0;
    cs_d     = (state_d == LEAD) || (state_d == XFER) || (state_d == TRAIL);
    busy_d   = (state_d != IDLE);
    done_d   = (state_q == TRAIL) && (state_d == GAP);
    ready_d  = (state_d == IDLE) && bus.en_i;
    if ((state_q == IDLE) || (state_d == IDLE)) begin
      sck_d = bus.cpol_i;
    end else if (fire) begin
      sck_d    = ~sck_q;
      pos_d    = ~sck_q;
      neg_d    = sck_q;
      sample_d = leading ^ cpha_q;
      shift_d  = (leading ~^ cpha_q) && !final_edge;
    end
  end

  // Config is captured only on acceptance so mid-transfer input changes are inert.
  always_comb begin
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    div_d      = div_q;
    len_d      = len_q;
    trail_d    = trail_q;
    gap_d      = gap_q;
    edge_cnt_d = edge_cnt_q;
    if (accept) begin
      cpol_d     = bus.cpol_i;
      cpha_d     = bus.cpha_i;
      div_d      = bus.clk_div_i;
      len_d      = bus.len_i;
      trail_d    = bus.trail_i;
      gap_d      = bus.gap_i;
      edge_cnt_d = '0;
    end else if (fire) begin
      edge_cnt_d = edge_cnt_q + 1'b1;
    end
    xfer_end_d = (state_d == XFER) && (xfer_end_q || (fire && final_edge));
  end

  always_comb begin
    half_load = ((state_q == LEAD) && (state_d == XFER)) || fire;
    half_dec  = (state_q == XFER);
    dly_load  = accept
             || ((state_q == XFER)  && (state_d == TRAIL))
             || ((state_q == TRAIL) && (state_d == GAP));
    dly_val   = accept ? bus.lead_i : ((state_q == XFER) ? trail_q : gap_q);
    dly_dec   = (state_q == LEAD) || (state_q == TRAIL) || (state_q == GAP);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      div_q      <= '0;
      len_q      <= '0;
      trail_q    <= '0;
      gap_q      <= '0;
      edge_cnt_q <= '0;
      xfer_end_q <= 1'b0;
      sck_q      <= 1'b0;
      pos_q      <= 1'b0;
      neg_q      <= 1'b0;
      sample_q   <= 1'b0;
      shift_q    <= 1'b0;
      cs_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      div_q      <= div_d;
      len_q      <= len_d;
      trail_q    <= trail_d;
      gap_q      <= gap_d;
      edge_cnt_q <= edge_cnt_d;
      xfer_end_q <= xfer_end_d;
      sck_q      <= sck_d;
      pos_q      <= pos_d;
      neg_q      <= neg_d;
      sample_q   <= sample_d;
      shift_q    <= shift_d;
      cs_q       <= cs_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  spi_sckgen_div #(.WIDTH(DIV_WIDTH)) u_half (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (half_load),
    .load_val_i (div_q),
    .dec_i      (half_dec),
    .zero_o     (half_zero)
  );

  spi_sckgen_div #(.WIDTH(DLY_WIDTH)) u_dly (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (dly_load),
    .load_val_i (dly_val),
    .dec_i      (dly_dec),
    .zero_o     (dly_zero)
  );

  assign bus.ready_o     = ready_q;
  assign bus.sck_o       = sck_q;
  assign bus.pos_edge_o  = pos_q;
  assign bus.neg_edge_o  = neg_q;
  assign bus.sample_o    = sample_q;
  assign bus.shift_o     = shift_q;
  assign bus.cs_active_o = cs_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;

endmodule

// File: tb/tb_spi_sckgen.sv
// Self-checking bench for spi_sckgen: per-cycle comparison against a timeline
// model derived from the transfer arithmetic, plus scenario-specific checks.
module tb_spi_sckgen;
  import spi_define::*;

  typedef struct {
    int cpol; int cpha; int div; int len; int lead; int trail; int gap;
  } cfg_t;

  logic clk_i = 1'b0;
  logic rst_i;
  int   checks = 0;
  int   failures = 0;
  logic [8:0] act [0:1023];

  spi_sckgen_if bus ();

  spi_sckgen dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Output vector layout: {sck, pos, neg, sample, shift, cs, busy, done, ready}
  function automatic logic [8:0] outs();
    return {bus.sck_o, bus.pos_edge_o, bus.neg_edge_o, bus.sample_o, bus.shift_o,
            bus.cs_active_o, bus.busy_o, bus.done_o, bus.ready_o};
  endfunction

  // Offsets are cycles after the acceptance cycle (offset 0).
  function automatic int last_edge_off(cfg_t c);
    return 1 + (c.lead + 1) + 2 * (c.len + 1) * (c.div + 1);
  endfunction

  function automatic int idle_off(cfg_t c);
    return last_edge_off(c) + c.trail + 2 + c.gap + 1;
  endfunction

  function automatic logic [8:0] model(cfg_t c, int k);
    int base, d, n, ne, e, g;
    logic sck, strobe, lead_e, smp, shf;
    if (k == 0 || k >= idle_off(c)) return {c.cpol[0], 7'b0, 1'b1};
    base = 2 + c.lead;
    d    = c.div + 1;
    n    = 2 * (c.len + 1);
    g    = last_edge_off(c) + c.trail + 2;
    ne   = (k < base + d) ? 0 : (k - base) / d;
    if (ne > n) ne = n;
    sck    = c.cpol[0] ^ ne[0];
    e      = (k - base) / d;
    strobe = (k >= base + d) && ((k - base) % d == 0) && (e <= n);
    lead_e = e[0];
    smp    = strobe && (lead_e != c.cpha[0]);
    shf    = strobe && (lead_e == c.cpha[0]) && (e != n);
    return {sck, strobe && sck, strobe && !sck, smp, shf, k < g, 1'b1, k == g, 1'b0};
  endfunction

  task automatic set_cfg(input cfg_t c);
    bus.cpol_i    = c.cpol[0];
    bus.cpha_i    = c.cpha[0];
    bus.clk_div_i = DIV_WIDTH_DEF'(c.div);
    bus.len_i     = LEN_WIDTH_DEF'(c.len);
    bus.lead_i    = DLY_WIDTH_DEF'(c.lead);
    bus.trail_i   = DLY_WIDTH_DEF'(c.trail);
    bus.gap_i     = DLY_WIDTH_DEF'(c.gap);
  endtask

  task automatic scramble_cfg();
    bus.cpol_i    = 1'($urandom);
    bus.cpha_i    = 1'($urandom);
    bus.clk_div_i = DIV_WIDTH_DEF'($urandom);
    bus.len_i     = LEN_WIDTH_DEF'($urandom);
    bus.lead_i    = DLY_WIDTH_DEF'($urandom);
    bus.trail_i   = DLY_WIDTH_DEF'($urandom);
    bus.gap_i     = DLY_WIDTH_DEF'($urandom);
  endtask

  function automatic cfg_t rand_cfg(int max_div);
    cfg_t c;
    c.cpol  = $urandom_range(0, 1);
    c.cpha  = $urandom_range(0, 1);
    c.div   = $urandom_range(0, max_div);
    c.len   = $urandom_range(0, 31);
    c.lead  = $urandom_range(0, 15);
    c.trail = $urandom_range(0, 15);
    c.gap   = $urandom_range(0, 15);
    return c;
  endfunction

  // Starts one transfer from IDLE and records outputs for offsets 0..ncyc.
  task automatic run_xfer(input cfg_t c, input int ncyc, input bit scr, input bit hold);
    int ie, ce;
    ie = idle_off(c);
    ce = last_edge_off(c);
    @(posedge clk_i); #1;
    set_cfg(c);
    bus.en_i    = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk_i); #1;
    bus.start_i = 1'b1;
    @(negedge clk_i);
    act[0] = outs();
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk_i); #1;
      if (hold) bus.start_i = (k < ncyc);
      else      bus.start_i = (k < ie) ? 1'($urandom) : 1'b0;
      if (scr && k < ce) scramble_cfg();
      else               set_cfg(c);
      @(negedge clk_i);
      act[k] = outs();
    end
  endtask

  task automatic test_reset();
    logic [8:0] exp;
    @(posedge clk_i); #1;
    rst_i = 1'b1; bus.en_i = 1'b1; bus.start_i = 1'b1; bus.cpol_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (outs() !== 9'b0) begin
      failures++;
      $display("[TB] FAIL reset_values got=%b exp=%b", outs(), 9'b0);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0; bus.start_i = 1'b0;
    @(negedge clk_i);
    for (int i = 0; i < 2; i++) begin
      exp = {bus.cpol_i, 7'b0, 1'b1};
      @(posedge clk_i); #1;
      bus.cpol_i = ~bus.cpol_i;
      @(negedge clk_i);
      checks++;
      if (outs() !== exp) begin
        failures++;
        $display("[TB] FAIL idle_cpol_track i=%0d got=%b exp=%b", i, outs(), exp);
      end
    end
  endtask

  task automatic test_mode0();
    cfg_t c = '{0, 0, 1, 7, 0, 0, 0};
    int n, nsmp, nshf;
    n = idle_off(c);
    run_xfer(c, n, 1'b1, 1'b0);
    nsmp = 0; nshf = 0;
    for (int k = 0; k <= n; k++) begin
      checks++;
      if (act[k] !== model(c, k)) begin
        failures++;
        $display("[TB] FAIL mode0 k=%0d got=%b exp=%b", k, act[k], model(c, k));
      end
      if (act[k][5]) nsmp++;
      if (act[k][4]) nshf++;
    end
    checks++;
    if (nsmp != 8 || nshf != 7) begin
      failures++;
      $display("[TB] FAIL mode0_strobe_counts sample=%0d shift=%0d exp 8/7", nsmp, nshf);
    end
    checks++;
    if ({act[1][3], act[3][8], act[4][8], act[34][6], act[36][1], act[36][3], act[37][0]} !== 7'b1011101) begin
      failures++;
      $display("[TB] FAIL mode0_milestones got=%b exp=1011101",
               {act[1][3], act[3][8], act[4][8], act[34][6], act[36][1], act[36][3], act[37][0]});
    end
  endtask

  task automatic test_mode3();
    cfg_t c = '{1, 1, 3, 3, 1, 0, 0};
    int n, nsmp_rise, nshf_fall;
    n = idle_off(c);
    run_xfer(c, n, 1'b1, 1'b0);
    nsmp_rise = 0; nshf_fall = 0;
    for (int k = 0; k <= n; k++) begin
      checks++;
      if (act[k] !== model(c, k)) begin
        failures++;
        $display("[TB] FAIL mode3 k=%0d got=%b exp=%b", k, act[k], model(c, k));
      end
      if (act[k][5] && act[k][7]) nsmp_rise++;
      if (act[k][4] && act[k][6]) nshf_fall++;
    end
    checks++;
    if (nsmp_rise != 4 || nshf_fall != 4 || act[6][8] !== 1'b1 || act[7][8] !== 1'b0 || act[n][8] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mode3_edges smp_rise=%0d shf_fall=%0d sck6=%b sck7=%b sck_end=%b exp 4 4 1 0 1",
               nsmp_rise, nshf_fall, act[6][8], act[7][8], act[n][8]);
    end
  endtask

  task automatic test_min_timing();
    cfg_t c = '{0, 0, 0, 0, 2, 3, 1};
    int n, nbusy;
    n = idle_off(c);
    run_xfer(c, n, 1'b0, 1'b0);
    nbusy = 0;
    for (int k = 0; k <= n; k++) begin
      checks++;
      if (act[k] !== model(c, k)) begin
        failures++;
        $display("[TB] FAIL min_timing k=%0d got=%b exp=%b", k, act[k], model(c, k));
      end
      if (act[k][2]) nbusy++;
    end
    checks++;
    if (nbusy != 12 || act[5][7] !== 1'b1 || act[6][6] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL min_timing_busy busy=%0d pos5=%b neg6=%b exp 12 1 1", nbusy, act[5][7], act[6][6]);
    end
  endtask

  task automatic test_random();
    cfg_t c;
    int n;
    for (int t = 0; t < 10; t++) begin
      if (t == 0)      c = '{0, 1, 0, 31, 0, 0, 0};
      else if (t == 1) c = '{1, 0, 255, 0, 15, 15, 15};
      else             c = rand_cfg(7);
      n = idle_off(c);
      run_xfer(c, n, 1'b1, 1'b0);
      for (int k = 0; k <= n; k++) begin
        checks++;
        if (act[k] !== model(c, k)) begin
          failures++;
          $display("[TB] FAIL random t=%0d k=%0d div=%0d len=%0d got=%b exp=%b",
                   t, k, c.div, c.len, act[k], model(c, k));
        end
      end
    end
  endtask

  task automatic test_abort();
    cfg_t c, c2;
    logic [8:0] exp;
    int e5;
    c = rand_cfg(3);
    c.len = $urandom_range(3, 31);
    e5 = 2 + c.lead + 5 * (c.div + 1);
    @(posedge clk_i); #1;
    set_cfg(c); bus.en_i = 1'b1; bus.start_i = 1'b0;
    @(posedge clk_i); #1;
    bus.start_i = 1'b1;
    for (int k = 1; k <= e5 + 4; k++) begin
      @(posedge clk_i); #1;
      bus.start_i = 1'b0;
      bus.en_i    = (k != e5);
      @(negedge clk_i);
      if (k <= e5)          exp = model(c, k);
      else if (k == e5 + 1) exp = {c.cpol[0], 8'b0};
      else                  exp = {c.cpol[0], 7'b0, 1'b1};
      checks++;
      if (outs() !== exp) begin
        failures++;
        $display("[TB] FAIL abort k=%0d e5=%0d got=%b exp=%b", k, e5, outs(), exp);
      end
    end
    c2 = rand_cfg(3);
    run_xfer(c2, idle_off(c2), 1'b0, 1'b0);
    for (int k = 0; k <= idle_off(c2); k++) begin
      checks++;
      if (act[k] !== model(c2, k)) begin
        failures++;
        $display("[TB] FAIL abort_restart k=%0d got=%b exp=%b", k, act[k], model(c2, k));
      end
    end
  endtask

  task automatic test_back_to_back();
    cfg_t c;
    logic [8:0] exp;
    int ie, ncs_low;
    c = rand_cfg(2);
    c.len = $urandom_range(0, 3);
    c.gap = 2;
    ie = idle_off(c);
    run_xfer(c, 2 * ie, 1'b0, 1'b1);
    ncs_low = 0;
    for (int k = 0; k <= 2 * ie; k++) begin
      exp = (k <= ie) ? model(c, k) : model(c, k - ie);
      checks++;
      if (act[k] !== exp) begin
        failures++;
        $display("[TB] FAIL back_to_back k=%0d got=%b exp=%b", k, act[k], exp);
      end
      if (k >= 1 && k <= ie + 1 && !act[k][3]) ncs_low++;
    end
    checks++;
    if (ncs_low != 4) begin
      failures++;
      $display("[TB] FAIL back_to_back_cs_gap got=%0d exp=4", ncs_low);
    end
  endtask

  task automatic test_reset_mid();
    cfg_t c;
    int ce;
    c = rand_cfg(3);
    c.cpol = 1;
    ce = last_edge_off(c);
    @(posedge clk_i); #1;
    set_cfg(c); bus.en_i = 1'b1; bus.start_i = 1'b0;
    @(posedge clk_i); #1;
    bus.start_i = 1'b1;
    for (int k = 1; k <= ce + 3; k++) begin
      @(posedge clk_i); #1;
      bus.start_i = 1'b0;
      rst_i = (k == ce + 1);
      @(negedge clk_i);
      if (k <= ce + 1) begin
        checks++;
        if (outs() !== model(c, k)) begin
          failures++;
          $display("[TB] FAIL reset_mid_pre k=%0d got=%b exp=%b", k, outs(), model(c, k));
        end
      end else if (k == ce + 2) begin
        checks++;
        if (outs() !== 9'b0) begin
          failures++;
          $display("[TB] FAIL reset_mid_values got=%b exp=%b", outs(), 9'b0);
        end
      end else begin
        checks++;
        if (outs() !== 9'b1_0000_0001) begin
          failures++;
          $display("[TB] FAIL reset_mid_recover got=%b exp=%b", outs(), 9'b1_0000_0001);
        end
      end
    end
  endtask

  initial begin
    rst_i = 1'b1;
    bus.en_i = 1'b0; bus.start_i = 1'b0;
    set_cfg('{0, 0, 0, 0, 0, 0, 0});
    test_reset();
    test_mode0();
    test_mode3();
    test_min_timing();
    test_random();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
